uart_tx_sniffer: RTL and testbench

//  Simulation-side receiver sitting directly downstream of the SoC uart_tx_pin.

---
 rtl/uart_tx_sniffer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_tx_sniffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sniffer.sv
// -----------------------------------------------------------------------------
// uart_tx_sniffer
//
// Purpose:
//   Receiver that sits directly downstream of the SoC uart_tx_pin. It turns
//   the UART frames sent by firmware back into bytes and buffers them in a
//   small first-word-fall-through FIFO. A testbench can then print or compare
//   console output. The design is synthesisable, so it also works on an FPGA
//   as a loopback console monitor.
//
// Configuration macro:
//   UART_SNIFF_PARITY_EN  When this macro is defined, frames are 8E1 (even
//                         parity over the 8 data bits) and parity_err_o is
//                         live. When it is undefined, frames are 8N1 and
//                         parity_err_o is tied to 0.
//
// Parameters:
//   CLK_DIV     clk cycles per UART bit (>= 4)
//   FIFO_DEPTH  FIFO entries, power of two (2..256)
//   CNT_W       width of byte_cnt_o
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-high reset
//   rx_pin_i      serial line, idle high
//   rd_en_i       pop the head byte (ignored when the FIFO is empty)
//   rd_data_o     head byte of the FIFO (combinational)
//   empty_o       FIFO holds no bytes
//   full_o        FIFO holds FIFO_DEPTH bytes
//   frame_err_o   1-cycle pulse: stop bit was sampled low
//   parity_err_o  1-cycle pulse: parity mismatch
//   overflow_o    sticky: a good byte was dropped because the FIFO was full
//   byte_cnt_o    number of bytes accepted into the FIFO (wraps)
// -----------------------------------------------------------------------------
module uart_tx_sniffer #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_pin_i,
  input  logic             rd_en_i,
  output logic [7:0]       rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             frame_err_o,
  output logic             parity_err_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] byte_cnt_o
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = AW + 1;

  localparam logic [DIV_W-1:0] BIT_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BIT_HALF = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [LVL_W-1:0] DEPTH_C  = LVL_W'(FIFO_DEPTH);

`ifdef UART_SNIFF_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;
`endif

  state_e state_q, state_d;

  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             push_req;
`ifdef UART_SNIFF_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             overflow_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic             pop, push_ok;

  // Two-flop synchroniser on the line. A third flop keeps the previous
  // synchronised value so that IDLE can detect a falling edge. All three
  // flops reset high, which is the idle line level, so leaving reset can
  // never look like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_pin_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Receiver state register, together with the bit timer, the bit index,
  // the data shift register and the registered error pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_SNIFF_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_SNIFF_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Receiver next-state logic. The START state samples half a bit after
  // the falling edge to find the middle of the start bit. Every later
  // sample is taken one full bit period after the previous one, so each
  // sample lands near the centre of its bit. push_req is raised in the
  // cycle when the stop bit is sampled good; the FIFO captures the byte
  // on that same clock edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + DIV_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
`ifdef UART_SNIFF_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
`ifdef UART_SNIFF_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (rx_prev_q && !rx_s_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == BIT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_SNIFF_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_SNIFF_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bad_d = rx_s_q ^ (^shift_q);
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
`ifdef UART_SNIFF_PARITY_EN
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
            state_d      = ST_IDLE;
`endif
          end else begin
            push_req = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        // A held-low line stays here, so it cannot re-trigger a frame.
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pop     = rd_en_i && (level_q != '0);
  assign push_ok = push_req && ((level_q != DEPTH_C) || pop);

  // FIFO storage and bookkeeping. When the FIFO is full, a push still
  // goes in if a pop happens on the same edge. Otherwise the byte is
  // dropped and the sticky overflow flag is set. The pointers are exactly
  // log2(depth) bits wide, so they wrap on their own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
        byte_cnt_q      <= byte_cnt_q + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop && !push_ok) begin
        level_q <= level_q - LVL_W'(1);
      end
      if (push_req && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign rd_data_o   = mem_q[rd_ptr_q];
  assign empty_o     = (level_q == '0);
  assign full_o      = (level_q == DEPTH_C);
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
  assign byte_cnt_o  = byte_cnt_q;
`ifdef UART_SNIFF_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sniffer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sniffer
//
// Purpose:
//   Self-checking bench for uart_tx_sniffer, built with CLK_DIV=16 and
//   FIFO_DEPTH=4. It sends serial frames bit by bit and compares the FIFO
//   contents, the flags and the byte count against expectations. Those
//   expectations come from constants, a vector table, or a queue model of
//   the receive FIFO. The parity test is compiled in only when
//   UART_SNIFF_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_sniffer;

  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;
`ifdef UART_SNIFF_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // The falling edge needs two synchroniser flops plus one registered edge
  // detection before START begins. After that come half a bit to reach the
  // centre of the start bit, then one bit period per following bit up to
  // the stop sample. The byte becomes visible on the edge that ends the
  // stop-sample cycle.
  localparam int PUSH_TICK = 3 + CLK_DIV / 2 + CLK_DIV * (NBITS - 1);

  logic             clk, rst, rxPin, rdEn;
  logic [7:0]       rdData;
  logic             empty, full, frameErr, parityErr, overflow;
  logic [CNT_W-1:0] byteCnt;

  int compared      = 0;
  int mismatched    = 0;
  int frameErrSeen  = 0;
  int parityErrSeen = 0;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    logic       expFrameErr;
    logic       expPush;
  } frameVec_t;

  frameVec_t vecs [6];

  uart_tx_sniffer #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_pin_i    (rxPin),
    .rd_en_i     (rdEn),
    .rd_data_o   (rdData),
    .empty_o     (empty),
    .full_o      (full),
    .frame_err_o (frameErr),
    .parity_err_o(parityErr),
    .overflow_o  (overflow),
    .byte_cnt_o  (byteCnt)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts error pulses, sampled mid-cycle, so that tests can compare
  // how many pulses arrived against how many were expected.
  always @(negedge clk) begin
    if (!rst) begin
      if (frameErr)  frameErrSeen++;
      if (parityErr) parityErrSeen++;
    end
  end

  // Drives the line and the pop request, then advances one clock. The
  // DUT outputs are stable and readable 1 ns after that edge.
  task automatic applyStimulus(input logic rx, input logic rd);
    rxPin = rx;
    rdEn  = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_empty",     32'(empty),     32'd1);
    checkOutput("rst_full",      32'(full),      32'd0);
    checkOutput("rst_frame_err", 32'(frameErr),  32'd0);
    checkOutput("rst_par_err",   32'(parityErr), 32'd0);
    checkOutput("rst_overflow",  32'(overflow),  32'd0);
    checkOutput("rst_byte_cnt",  32'(byteCnt),   32'd0);
    checkOutput("rst_rd_data",   32'(rdData),    32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
  endtask

  // Sends one frame, LSB first. With timingCheck set, it also checks the
  // push latency and the error pulses around the stop-sample cycle. The
  // latency check assumes the FIFO was empty before the frame. With
  // popAtPush set, the pop is requested on the same edge as the push. A
  // non-zero abortAt stops driving after that many cycles. holdLow keeps
  // the line low for that many cycles after the stop bit.
  task automatic sendFrame(input logic [7:0] data, input logic stopVal,
                           input logic parFlip, input bit timingCheck,
                           input bit popAtPush, input int abortAt,
                           input int holdLow);
    logic [NBITS-1:0] bitsV;
    logic             expPush;
    int               t;
    bitsV    = '1;
    bitsV[0] = 1'b0;
    for (int i = 0; i < 8; i++) bitsV[1+i] = data[i];
`ifdef UART_SNIFF_PARITY_EN
    bitsV[9] = (^data) ^ parFlip;
`endif
    bitsV[NBITS-1] = stopVal;
    expPush = stopVal && !parFlip;
    t = 0;
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        if (abortAt != 0 && t == abortAt) return;
        applyStimulus(bitsV[b], popAtPush && (t == PUSH_TICK - 1));
        t++;
        if (timingCheck) begin
          if (t == PUSH_TICK - 1 && expPush)
            checkOutput("pre_push_empty", 32'(empty), 32'd1);
          if (t == PUSH_TICK) begin
            if (expPush) begin
              checkOutput("push_empty", 32'(empty), 32'd0);
              checkOutput("push_data", 32'(rdData), 32'(data));
            end
            checkOutput("frame_err_pulse", 32'(frameErr), 32'(!stopVal));
            checkOutput("par_err_pulse", 32'(parityErr),
                        32'(stopVal && parFlip));
          end
          if (t == PUSH_TICK + 1) begin
            checkOutput("frame_err_end", 32'(frameErr), 32'd0);
            checkOutput("par_err_end", 32'(parityErr), 32'd0);
          end
        end
      end
    end
    for (int i = 0; i < holdLow; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
  endtask

  task automatic popCheck(input string name, input logic [7:0] exp);
    checkOutput({name, "_nonempty"}, 32'(empty), 32'd0);
    checkOutput({name, "_data"}, 32'(rdData), 32'(exp));
    applyStimulus(1'b1, 1'b1);
  endtask

  initial begin
    logic [7:0] modelQ[$];
    int         expCnt, fe0, pe0, nPop;
    logic       expOvf, stopOk, parFlip;
    logic [7:0] data;

    vecs[0] = '{data: 8'h00, stopBit: 1'b1, expFrameErr: 1'b0, expPush: 1'b1};
    vecs[1] = '{data: 8'hFF, stopBit: 1'b1, expFrameErr: 1'b0, expPush: 1'b1};
    vecs[2] = '{data: 8'h80, stopBit: 1'b0, expFrameErr: 1'b1, expPush: 1'b0};
    vecs[3] = '{data: 8'h01, stopBit: 1'b1, expFrameErr: 1'b0, expPush: 1'b1};
    vecs[4] = '{data: 8'hC3, stopBit: 1'b0, expFrameErr: 1'b1, expPush: 1'b0};
    vecs[5] = '{data: 8'h7F, stopBit: 1'b1, expFrameErr: 1'b0, expPush: 1'b1};

    rxPin = 1'b1;
    rdEn  = 1'b0;
    rst   = 1'b0;
    doReset();

    // Two back-to-back bytes, with exact push latency on the first.
    sendFrame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    sendFrame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    popCheck("t1_first", 8'h55);
    popCheck("t1_second", 8'hA3);
    checkOutput("t1_empty", 32'(empty), 32'd1);
    checkOutput("t1_byte_cnt", 32'(byteCnt), 32'd2);

    // A short low glitch must be rejected silently, leaving the receiver
    // ready for the next frame.
    fe0 = frameErrSeen;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("t2_empty", 32'(empty), 32'd1);
    checkOutput("t2_no_frame_err", 32'(frameErrSeen - fe0), 32'd0);
    checkOutput("t2_byte_cnt", 32'(byteCnt), 32'd2);
    sendFrame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    popCheck("t2_after", 8'h5A);

    // Bad stop bit followed by a long break, then a good frame.
    fe0 = frameErrSeen;
    sendFrame(8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 0, 100);
    sendFrame(8'h42, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("t3_frame_err_count", 32'(frameErrSeen - fe0), 32'd1);
    popCheck("t3_only", 8'h42);
    checkOutput("t3_empty", 32'(empty), 32'd1);

    // Vector table: good and framing-error frames, popping each good one.
    for (int v = 0; v < 6; v++) begin
      fe0 = frameErrSeen;
      sendFrame(vecs[v].data, vecs[v].stopBit, 1'b0, 1'b1, 1'b0, 0, 0);
      checkOutput("vec_frame_err", 32'(frameErrSeen - fe0),
                  32'(vecs[v].expFrameErr));
      checkOutput("vec_empty", 32'(empty), 32'(!vecs[v].expPush));
      if (vecs[v].expPush) popCheck("vec_pop", vecs[v].data);
    end

    // Fill, overflow, then push and pop on the same edge while full.
    doReset();
    for (int i = 1; i <= 4; i++)
      sendFrame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("t4_full", 32'(full), 32'd1);
    checkOutput("t4_no_ovf", 32'(overflow), 32'd0);
    sendFrame(8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("t4_ovf", 32'(overflow), 32'd1);
    checkOutput("t4_cnt4", 32'(byteCnt), 32'd4);
    checkOutput("t4_full5", 32'(full), 32'd1);
    sendFrame(8'h06, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    checkOutput("t4_full6", 32'(full), 32'd1);
    checkOutput("t4_ovf6", 32'(overflow), 32'd1);
    checkOutput("t4_cnt5", 32'(byteCnt), 32'd5);
    popCheck("t4_q0", 8'h02);
    popCheck("t4_q1", 8'h03);
    popCheck("t4_q2", 8'h04);
    popCheck("t4_q3", 8'h06);
    checkOutput("t4_empty", 32'(empty), 32'd1);

    // Reset in the middle of a frame abandons it.
    doReset();
    sendFrame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 60, 0);
    doReset();
    sendFrame(8'h31, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("t5_cnt", 32'(byteCnt), 32'd1);
    popCheck("t5_only", 8'h31);
    checkOutput("t5_empty", 32'(empty), 32'd1);

`ifdef UART_SNIFF_PARITY_EN
    // Even parity: a correct parity bit is accepted, a flipped one is
    // reported and the byte is discarded.
    doReset();
    pe0 = parityErrSeen;
    sendFrame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("t6_cnt1", 32'(byteCnt), 32'd1);
    sendFrame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    checkOutput("t6_cnt_same", 32'(byteCnt), 32'd1);
    checkOutput("t6_par_count", 32'(parityErrSeen - pe0), 32'd1);
    popCheck("t6_only", 8'h03);
    checkOutput("t6_empty", 32'(empty), 32'd1);
`endif

    // Random frames checked against a queue model of the FIFO.
    doReset();
    expCnt = 0;
    expOvf = 1'b0;
    for (int n = 0; n < 40; n++) begin
      data    = 8'($urandom);
      stopOk  = ($urandom_range(0, 5) != 0);
`ifdef UART_SNIFF_PARITY_EN
      parFlip = ($urandom_range(0, 5) == 0);
`else
      parFlip = 1'b0;
`endif
      fe0 = frameErrSeen;
      pe0 = parityErrSeen;
      sendFrame(data, stopOk, parFlip, 1'b0, 1'b0, 0, 0);
      if (stopOk && !parFlip) begin
        if (modelQ.size() < FIFO_DEPTH) begin
          modelQ.push_back(data);
          expCnt++;
        end else begin
          expOvf = 1'b1;
        end
      end
      checkOutput("rnd_frame_err", 32'(frameErrSeen - fe0), 32'(!stopOk));
      checkOutput("rnd_par_err", 32'(parityErrSeen - pe0),
                  32'(stopOk && parFlip));
      checkOutput("rnd_byte_cnt", 32'(byteCnt), 32'(expCnt % (1 << CNT_W)));
      checkOutput("rnd_overflow", 32'(overflow), 32'(expOvf));
      checkOutput("rnd_empty", 32'(empty), 32'(modelQ.size() == 0));
      checkOutput("rnd_full", 32'(full), 32'(modelQ.size() == FIFO_DEPTH));
      nPop = ($urandom_range(0, 3) == 0) ? 3 : 0;
      for (int p = 0; p < nPop; p++) begin
        if (modelQ.size() > 0) begin
          checkOutput("rnd_rd_data", 32'(rdData), 32'(modelQ[0]));
          void'(modelQ.pop_front());
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("rnd_pop_empty", 32'(empty), 32'(modelQ.size() == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
